// File: rtl/genotipo_serial_loader.sv
// Byte-stream loader for the cartesian grid genotype: frames are assembled in a shadow
// buffer and copied into the active truth tables / output selectors only after verification.
module genotipo_serial_loader #(
  parameter int         ROW  = 2,
  parameter int         COL  = 3,
  parameter int         IN   = 4,
  parameter int         OUT  = 2,
  parameter logic [7:0] SYNC = 8'hA5,
  localparam int        SELW = $clog2(ROW*COL)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ROW-1:0][COL-1:0][15:0]  saidas_LE,
  output logic [OUT-1:0][SELW-1:0]       out_chrom,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int NLE = ROW * COL;
  localparam int NLB = 2 * NLE;
  localparam int CW  = $clog2(NLB + OUT) + 1;
  localparam int IW  = CW - 1;

  if (SELW > 8) begin : g_selw_chk
    $error("genotipo_serial_loader: selector width exceeds one byte");
  end
  if (IN < 1) begin : g_in_chk
    $error("genotipo_serial_loader: IN must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LE,
    S_LOAD_OUT,
    S_CHECK,
    S_COMMIT
  } state_t;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                          state_r, state_s;
  logic [CW-1:0]                   cnt_r;
  logic [7:0]                      chk_r;
  logic                            range_r;
  logic [15:0]                     shadow_le_r  [NLE];
  logic [SELW-1:0]                 shadow_sel_r [OUT];
  logic [ROW-1:0][COL-1:0][15:0]   le_r;
  logic [OUT-1:0][SELW-1:0]        sel_r;
  logic                            done_r, err_r;
  logic                            xfer_s, frame_ok_s, last_le_s, last_sel_s;

  assign in_ready   = (state_r != S_COMMIT);
  assign xfer_s     = in_valid & in_ready;
  assign last_le_s  = (cnt_r == CW'(NLB - 1));
  assign last_sel_s = (cnt_r == CW'(OUT - 1));
  assign frame_ok_s = (in_data == chk_r) && !range_r;

  // Next-state decode; every state except COMMIT waits for a transfer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (xfer_s && (in_data == SYNC)) state_s = S_LOAD_LE;
        else                             state_s = S_IDLE;
      end
      S_LOAD_LE: begin
        if (xfer_s && last_le_s) state_s = S_LOAD_OUT;
        else                     state_s = S_LOAD_LE;
      end
      S_LOAD_OUT: begin
        if (xfer_s && last_sel_s) state_s = S_CHECK;
        else                      state_s = S_LOAD_OUT;
      end
      S_CHECK: begin
        if (!xfer_s)         state_s = S_CHECK;
        else if (frame_ok_s) state_s = S_COMMIT;
        else                 state_s = S_IDLE;
      end
      S_COMMIT: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Byte counter, running checksum and selector range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      chk_r   <= 8'h00;
      range_r <= 1'b0;
    end else if (xfer_s) begin
      case (state_r)
        S_IDLE: begin
          cnt_r   <= {CW{1'b0}};
          chk_r   <= 8'h00;
          range_r <= 1'b0;
        end
        S_LOAD_LE: begin
          cnt_r <= last_le_s ? {CW{1'b0}} : cnt_r + CW'(1);
          chk_r <= chk_fold(chk_r, in_data);
        end
        S_LOAD_OUT: begin
          cnt_r <= last_sel_s ? {CW{1'b0}} : cnt_r + CW'(1);
          chk_r <= chk_fold(chk_r, in_data);
          // full byte is compared, so stray upper bits reject the frame
          if ({1'b0, in_data} >= 9'(NLE)) range_r <= 1'b1;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Shadow buffer: payload bytes land here, low byte of each truth table first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NLE; e++) shadow_le_r[e] <= 16'h0000;
      for (int k = 0; k < OUT; k++) shadow_sel_r[k] <= {SELW{1'b0}};
    end else if (xfer_s && (state_r == S_LOAD_LE)) begin
      for (int e = 0; e < NLE; e++) begin
        if (cnt_r[CW-1:1] == IW'(e)) begin
          if (cnt_r[0]) shadow_le_r[e][15:8] <= in_data;
          else          shadow_le_r[e][7:0]  <= in_data;
        end
      end
    end else if (xfer_s && (state_r == S_LOAD_OUT)) begin
      for (int k = 0; k < OUT; k++) begin
        if (cnt_r == CW'(k)) shadow_sel_r[k] <= in_data[SELW-1:0];
      end
    end
  end

  // Active registers and status pulses; done rises with the committed contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      le_r   <= {(NLE*16){1'b0}};
      sel_r  <= {(OUT*SELW){1'b0}};
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= (state_r == S_COMMIT);
      err_r  <= (state_r == S_CHECK) && xfer_s && !frame_ok_s;
      if (state_r == S_COMMIT) begin
        for (int i = 0; i < ROW; i++)
          for (int j = 0; j < COL; j++)
            le_r[i][j] <= shadow_le_r[i*COL + j];
        for (int k = 0; k < OUT; k++) sel_r[k] <= shadow_sel_r[k];
      end
    end
  end

  assign saidas_LE = le_r;
  assign out_chrom = sel_r;
  assign busy      = (state_r != S_IDLE);
  assign done      = done_r;
  assign err       = err_r;

endmodule
